// File: rtl/vga_if.sv
// VGA pixel stream bundle passed between draw stages.
//   hcount/vcount : pixel coordinates
//   hsync/vsync   : sync pulses
//   hblnk/vblnk   : blanking flags
//   rgb           : 4:4:4 pixel colour
// Modports: in (consumer side), out (producer side).
interface vga_if;
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;

    modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
    modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/char_hp_bar_draw.sv
// Overlays a segmented HP bar on the VGA pixel stream, one clock of latency.
// HP is latched once per frame (at hcount==0 && vcount==0) so the bar never tears.
// Optional damage flash: define CHAR_HP_FLASH_EN to blink live segments for
// FLASH_FRAMES frames after each HP decrease.
// Ports:
//   clk      pixel clock
//   rst      synchronous active-high reset
//   char_hp  current character HP (clamped to HP_MAX)
//   vga_in   incoming pixel stream
//   vga_out  same stream delayed 1 clk with the bar drawn in
//   hp_zero  registered flag, high while the latched HP is 0
module char_hp_bar_draw #(
    parameter int unsigned HP_MAX       = 10,
    parameter int unsigned BAR_X        = 16,
    parameter int unsigned BAR_Y        = 16,
    parameter int unsigned SEG_W        = 16,
    parameter int unsigned SEG_H        = 12,
    parameter int unsigned SEG_GAP      = 4,
    parameter int unsigned FLASH_FRAMES = 30,
    parameter logic [11:0] COLOR_FULL   = 12'hF00,
    parameter logic [11:0] COLOR_EMPTY  = 12'h444,
    parameter logic [11:0] COLOR_FLASH  = 12'hFFF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] char_hp,
    vga_if.in          vga_in,
    vga_if.out         vga_out,
    output logic       hp_zero
);

    localparam int unsigned PITCH = SEG_W + SEG_GAP;
    localparam int unsigned POS_W = (PITCH > 1) ? $clog2(PITCH) : 1;
    localparam int unsigned CNT_W = $clog2(FLASH_FRAMES + 1);

    localparam logic [3:0]       HP_MAX_L    = 4'(HP_MAX);
    localparam logic [3:0]       SEG_LAST    = 4'(HP_MAX - 1);
    localparam logic [10:0]      BAR_X_L     = 11'(BAR_X);
    localparam logic [10:0]      BAR_Y_L     = 11'(BAR_Y);
    localparam logic [10:0]      BAR_Y_END_L = 11'(BAR_Y + SEG_H);
    localparam logic [POS_W-1:0] SEG_W_L     = POS_W'(SEG_W);
    localparam logic [POS_W-1:0] PITCH_LAST  = POS_W'(PITCH - 1);

    // Reject configurations the 4-bit HP path or the flash counter cannot represent.
    if (HP_MAX == 0 || HP_MAX > 15 || SEG_W == 0 || FLASH_FRAMES == 0 || CNT_W == 0) begin : g_param_check
        $error("char_hp_bar_draw: unsupported parameter set");
    end

    logic [3:0]       hp_lat;
    logic             frame_start_c;
    logic [3:0]       hp_new_c;
    logic [3:0]       hp_eff_c;

    logic             run_q, run_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic [3:0]       seg_q, seg_d;
    logic             run_start_c;
    logic             run_c;
    logic [POS_W-1:0] pos_c;
    logic [3:0]       seg_c;
    logic             in_seg_c;
    logic             flash_on_c;
    logic [11:0]      seg_color_c;

    // Frame-start detect and HP clamp; the frame-start pixel already sees the new HP.
    assign frame_start_c = (vga_in.hcount == 11'd0) && (vga_in.vcount == 11'd0);
    assign hp_new_c      = (char_hp > HP_MAX_L) ? HP_MAX_L : char_hp;
    assign hp_eff_c      = frame_start_c ? hp_new_c : hp_lat;

    // Segment position: the run restarts at x==BAR_X, so the current pixel uses the
    // restarted values directly rather than waiting a cycle.
    assign run_start_c = (vga_in.hcount == BAR_X_L);
    assign run_c       = run_start_c || run_q;
    assign pos_c       = run_start_c ? '0 : pos_q;
    assign seg_c       = run_start_c ? 4'd0 : seg_q;

    assign in_seg_c = run_c && (pos_c < SEG_W_L)
                   && (vga_in.vcount >= BAR_Y_L) && (vga_in.vcount < BAR_Y_END_L)
                   && !vga_in.hblnk && !vga_in.vblnk;

    // Running counter advance; stops after the last segment's pitch.
    always_comb begin
        run_d = run_q;
        pos_d = pos_q;
        seg_d = seg_q;
        if (run_c) begin
            if (pos_c == PITCH_LAST) begin
                pos_d = '0;
                seg_d = seg_c + 4'd1;
                run_d = (seg_c != SEG_LAST);
            end else begin
                pos_d = pos_c + POS_W'(1);
                seg_d = seg_c;
                run_d = 1'b1;
            end
        end
    end

`ifdef CHAR_HP_FLASH_EN
    typedef enum logic {
        S_IDLE,
        S_FLASH
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] flash_cnt_q, flash_cnt_d;
    logic [2:0]       frm_q;

    // Flash state, countdown and frame counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            flash_cnt_q <= '0;
            frm_q       <= 3'd0;
        end else begin
            state_q     <= state_d;
            flash_cnt_q <= flash_cnt_d;
            if (frame_start_c) begin
                frm_q <= frm_q + 3'd1;
            end
        end
    end

    // Decrease (compared after clamping) starts or reloads the flash; heals are ignored.
    always_comb begin
        state_d     = state_q;
        flash_cnt_d = flash_cnt_q;
        if (frame_start_c) begin
            case (state_q)
                S_IDLE: begin
                    if (hp_new_c < hp_lat) begin
                        state_d     = S_FLASH;
                        flash_cnt_d = CNT_W'(FLASH_FRAMES);
                    end
                end
                S_FLASH: begin
                    if (hp_new_c < hp_lat) begin
                        flash_cnt_d = CNT_W'(FLASH_FRAMES);
                    end else if (flash_cnt_q == CNT_W'(1)) begin
                        state_d     = S_IDLE;
                        flash_cnt_d = '0;
                    end else begin
                        flash_cnt_d = flash_cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_d     = S_IDLE;
                    flash_cnt_d = '0;
                end
            endcase
        end
    end

    assign flash_on_c = (state_q == S_FLASH) && frm_q[2];
`else
    assign flash_on_c = 1'b0;
`endif

    assign seg_color_c = (seg_c < hp_eff_c) ? (flash_on_c ? COLOR_FLASH : COLOR_FULL)
                                            : COLOR_EMPTY;

    // HP latch, run counter, and the 1-cycle output pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            hp_lat         <= HP_MAX_L;
            hp_zero        <= 1'b0;
            run_q          <= 1'b0;
            pos_q          <= '0;
            seg_q          <= 4'd0;
            vga_out.hcount <= 11'd0;
            vga_out.vcount <= 11'd0;
            vga_out.hsync  <= 1'b0;
            vga_out.vsync  <= 1'b0;
            vga_out.hblnk  <= 1'b0;
            vga_out.vblnk  <= 1'b0;
            vga_out.rgb    <= 12'd0;
        end else begin
            if (frame_start_c) begin
                hp_lat <= hp_new_c;
            end
            hp_zero        <= (hp_lat == 4'd0);
            run_q          <= run_d;
            pos_q          <= pos_d;
            seg_q          <= seg_d;
            vga_out.hcount <= vga_in.hcount;
            vga_out.vcount <= vga_in.vcount;
            vga_out.hsync  <= vga_in.hsync;
            vga_out.vsync  <= vga_in.vsync;
            vga_out.hblnk  <= vga_in.hblnk;
            vga_out.vblnk  <= vga_in.vblnk;
            vga_out.rgb    <= in_seg_c ? seg_color_c : vga_in.rgb;
        end
    end

endmodule

// File: tb/tb_char_hp_bar_draw.sv
// Bench for char_hp_bar_draw: table of single-frame vectors plus hand-written
// sequences for mid-frame HP change, blanking, mid-line reset and the flash timeline.
module tb_char_hp_bar_draw;

    localparam int H_LAST = 229;
`ifdef CHAR_HP_FLASH_EN
    localparam bit FLASH_EN = 1'b1;
`else
    localparam bit FLASH_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] char_hp = 4'd0;
    logic       hp_zero;

    vga_if vin();
    vga_if vout();

    char_hp_bar_draw dut (
        .clk     (clk),
        .rst     (rst),
        .char_hp (char_hp),
        .vga_in  (vin),
        .vga_out (vout),
        .hp_zero (hp_zero)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    int          field_err;
    int          rgb_err;
    string       field_msg;
    string       rgb_msg;
    logic [11:0] out_rgb [0:H_LAST];

    typedef struct {
        logic [3:0]  hp;
        int          v;
        int          h;
        bit          pass;
        logic [11:0] rgb;
        logic        zero;
    } vec_t;

    vec_t vecs [12];

    function automatic logic [11:0] pat(input int h, input int v);
        return 12'(h * 7 + v * 13 + 1);
    endfunction

    // Reference bar geometry by division, independent of the DUT's running counter.
    function automatic logic [11:0] exp_rgb(input int h, input int v, input logic hb,
                                            input logic vb, input int lat, input bit fl);
        int off;
        int k;
        int p;
        if (hb || vb || v < 16 || v >= 28 || h < 16) return pat(h, v);
        off = h - 16;
        k   = off / 20;
        p   = off % 20;
        if (k >= 10 || p >= 16) return pat(h, v);
        if (k < lat) return fl ? 12'hFFF : 12'hF00;
        return 12'h444;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One pixel per cycle: drive at negedge, sample 1 ns after the capturing posedge.
    task automatic drive_px(input int h, input int v, input logic hb, input logic vb,
                            input logic r, input logic [11:0] er);
        logic [10:0] eh;
        logic [10:0] ev;
        logic        ehs;
        logic        evs;
        logic        ehb;
        logic        evb;
        logic [11:0] erg;
        logic [31:0] hv;
        logic [31:0] vv;
        hv = h;
        vv = v;
        @(negedge clk);
        vin.hcount = 11'(h);
        vin.vcount = 11'(v);
        vin.hsync  = hv[2];
        vin.vsync  = ~vv[0];
        vin.hblnk  = hb;
        vin.vblnk  = vb;
        vin.rgb    = pat(h, v);
        rst        = r;
        @(posedge clk);
        #1;
        if (r) begin
            eh = '0; ev = '0; ehs = 1'b0; evs = 1'b0; ehb = 1'b0; evb = 1'b0; erg = '0;
        end else begin
            eh = 11'(h); ev = 11'(v); ehs = hv[2]; evs = ~vv[0]; ehb = hb; evb = vb; erg = er;
        end
        if ({vout.hcount, vout.vcount, vout.hsync, vout.vsync, vout.hblnk, vout.vblnk}
            !== {eh, ev, ehs, evs, ehb, evb}) begin
            if (field_err == 0)
                field_msg = $sformatf("first bad field at (%0d,%0d): h=%0d v=%0d hs=%b vs=%b hb=%b vb=%b",
                                      h, v, vout.hcount, vout.vcount, vout.hsync, vout.vsync,
                                      vout.hblnk, vout.vblnk);
            field_err++;
        end
        if (vout.rgb !== erg) begin
            if (rgb_err == 0)
                rgb_msg = $sformatf("first bad rgb at (%0d,%0d): got %h want %h", h, v, vout.rgb, erg);
            rgb_err++;
        end
        if (h >= 0 && h <= H_LAST) out_rgb[h] = vout.rgb;
    endtask

    // Optional frame-start pixel, then one full line; aggregated field and rgb checks.
    task automatic run_line(input int v, input bit fs, input int hb_lo, input int hb_hi,
                            input logic vb, input int rst_h, input int lat, input bit fl);
        logic hb;
        field_err = 0;
        rgb_err   = 0;
        if (fs) drive_px(0, 0, 1'b0, 1'b0, 1'b0, pat(0, 0));
        for (int h = 0; h <= H_LAST; h++) begin
            hb = (h >= hb_lo) && (h < hb_hi);
            drive_px(h, v, hb, vb, (h == rst_h), exp_rgb(h, v, hb, vb, lat, fl));
        end
        check($sformatf("fields line v%0d (bad pixel count)", v), field_err, 0);
        if (field_err != 0) $display("  %s", field_msg);
        check($sformatf("rgb line v%0d (bad pixel count)", v), rgb_err, 0);
        if (rgb_err != 0) $display("  %s", rgb_msg);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst        = 1'b1;
        vin.hcount = 11'd5;
        vin.vcount = 11'd5;
        vin.hsync  = 1'b1;
        vin.vsync  = 1'b1;
        vin.hblnk  = 1'b0;
        vin.vblnk  = 1'b0;
        vin.rgb    = 12'hABC;
        @(posedge clk);
        #1;
        check("reset vga_out", {vout.hcount, vout.vcount, vout.hsync, vout.vsync,
                                vout.hblnk, vout.vblnk, vout.rgb}, 0);
        check("reset hp_zero", hp_zero, 0);
    endtask

    function automatic int hp_sched(input int n);
        if (n <= 31) return 5;
        if (n <= 51) return 4;
        if (n <= 84) return 3;
        if (n <= 94) return 6;
        if (n <= 99) return 2;
        return 6;
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int m_lat;
        int m_cnt;
        int m_frm;
        int nw;
        bit m_fl;
        bit vis;
        int flash_seen;

        //          hp    v   h    pass  rgb       zero
        vecs[0]  = '{4'd7,  16, 16,  1'b0, 12'hF00, 1'b0};  // first live segment
        vecs[1]  = '{4'd7,  16, 156, 1'b0, 12'h444, 1'b0};  // segment 7 is empty
        vecs[2]  = '{4'd7,  16, 32,  1'b1, 12'h000, 1'b0};  // gap after segment 0
        vecs[3]  = '{4'd7,  16, 151, 1'b0, 12'hF00, 1'b0};  // last pixel of segment 6
        vecs[4]  = '{4'd7,  16, 152, 1'b1, 12'h000, 1'b0};  // first gap pixel after segment 6
        vecs[5]  = '{4'd15, 16, 211, 1'b0, 12'hF00, 1'b0};  // clamp: segment 9 live
        vecs[6]  = '{4'd15, 16, 212, 1'b1, 12'h000, 1'b0};  // right of the bar
        vecs[7]  = '{4'd0,  16, 16,  1'b0, 12'h444, 1'b1};  // zero HP
        vecs[8]  = '{4'd10, 27, 16,  1'b0, 12'hF00, 1'b0};  // last bar row
        vecs[9]  = '{4'd10, 28, 16,  1'b1, 12'h000, 1'b0};  // below the bar
        vecs[10] = '{4'd10, 16, 15,  1'b1, 12'h000, 1'b0};  // left of the bar
        vecs[11] = '{4'd9,  16, 196, 1'b0, 12'h444, 1'b0};  // segment 9 empty

        vin.hcount = '0; vin.vcount = '0; vin.hsync = 1'b0; vin.vsync = 1'b0;
        vin.hblnk = 1'b0; vin.vblnk = 1'b0; vin.rgb = '0;

        // Table: reset, latch HP in frame 1 (frm=1, never a flash-on frame), check one pixel.
        for (int i = 0; i < 12; i++) begin
            do_reset();
            char_hp = vecs[i].hp;
            lat = (vecs[i].hp > 4'd10) ? 10 : int'(vecs[i].hp);
            run_line(vecs[i].v, 1'b1, 0, 0, 1'b0, -1, lat, 1'b0);
            check($sformatf("vec%0d rgb(%0d,%0d)", i, vecs[i].h, vecs[i].v), out_rgb[vecs[i].h],
                  vecs[i].pass ? pat(vecs[i].h, vecs[i].v) : vecs[i].rgb);
            check($sformatf("vec%0d hp_zero", i), hp_zero, vecs[i].zero);
        end

        // Mid-frame HP change is only seen at the next frame start.
        do_reset();
        char_hp = 4'd7;
        run_line(8, 1'b1, 0, 0, 1'b0, -1, 7, 1'b0);
        char_hp = 4'd3;
        run_line(16, 1'b0, 0, 0, 1'b0, -1, 7, 1'b0);
        check("midframe seg6 still live", out_rgb[136], 12'hF00);
        check("midframe seg3 still live", out_rgb[76], 12'hF00);
        run_line(16, 1'b1, 0, 0, 1'b0, -1, 3, 1'b0);
        check("next frame seg3 empty", out_rgb[76], 12'h444);
        check("next frame seg2 live", out_rgb[56], 12'hF00);

        // Blanking passes rgb through, and the segment count survives an hblnk window.
        do_reset();
        char_hp = 4'd10;
        run_line(16, 1'b1, 100, 120, 1'b0, -1, 10, 1'b0);
        check("hblnk seg4 pixel passes", out_rgb[100], pat(100, 16));
        check("hblnk seg5 pixel passes", out_rgb[116], pat(116, 16));
        check("after hblnk seg5 drawn", out_rgb[120], 12'hF00);
        run_line(16, 1'b0, 0, 0, 1'b1, -1, 10, 1'b0);
        check("vblnk passes", out_rgb[16], pat(16, 16));

        // One-cycle reset mid-line: zero output, bar back to HP_MAX, hp_zero cleared.
        do_reset();
        char_hp = 4'd0;
        run_line(16, 1'b1, 0, 0, 1'b0, -1, 0, 1'b0);
        check("hp_zero set before reset", hp_zero, 1);
        run_line(16, 1'b1, 0, 0, 1'b0, 5, 10, 1'b0);
        check("reset pixel rgb", out_rgb[5], 0);
        check("post-reset seg0 HP_MAX", out_rgb[16], 12'hF00);
        check("post-reset seg9 HP_MAX", out_rgb[196], 12'hF00);
        check("post-reset hp_zero", hp_zero, 0);
        run_line(16, 1'b1, 0, 0, 1'b0, -1, 0, 1'b0);
        check("frame after reset seg0 empty", out_rgb[16], 12'h444);
        check("frame after reset hp_zero", hp_zero, 1);

        // Flash timeline: drops at frames 1, 32, 52 (reload), 95; heals at 85 and 100.
        do_reset();
        m_lat = 10; m_cnt = 0; m_frm = 0; m_fl = 1'b0;
        flash_seen = 0;
        for (int n = 1; n <= 104; n++) begin
            char_hp = 4'(hp_sched(n));
            nw = hp_sched(n);
            if (FLASH_EN) begin
                if (m_fl) begin
                    if (nw < m_lat) m_cnt = 30;
                    else if (m_cnt == 1) begin m_fl = 1'b0; m_cnt = 0; end
                    else m_cnt--;
                end else if (nw < m_lat) begin
                    m_fl = 1'b1;
                    m_cnt = 30;
                end
            end
            m_frm = (m_frm + 1) % 8;
            m_lat = nw;
            vis = m_fl && (m_frm >= 4);
            run_line(16, 1'b1, 0, 0, 1'b0, -1, m_lat, vis);
            if (out_rgb[16] == 12'hFFF) flash_seen++;
        end
        check("flash-on frame count", flash_seen, FLASH_EN ? 44 : 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
